// File: rtl/a8_bus_pkg.sv
// Shared types and constants for the Atari 8-bit bus capture block.
package a8_bus_pkg;

  localparam int unsigned TICK_W = 7;
  localparam logic [TICK_W-1:0] TICK_MAX = 7'd127;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
  } a8_cycle_t;

endpackage

// File: rtl/a8_bus_capture_if.sv
// Atari bus inputs plus the capture stream towards the consumer.
interface a8_bus_capture_if;

  logic        a8_clk;
  logic [15:0] a8_addr;
  logic [7:0]  a8_data;
  logic        a8_rw_n;

  logic        cap_valid;
  logic        cap_ready;
  logic [15:0] cap_addr;
  logic [7:0]  cap_data;
  logic        cap_rw_n;

  logic        ovf;
  logic        ovf_clr;
  logic        clk_alive;

  modport slave (
    input  a8_clk, a8_addr, a8_data, a8_rw_n, cap_ready, ovf_clr,
    output cap_valid, cap_addr, cap_data, cap_rw_n, ovf, clk_alive
  );

  modport master (
    output a8_clk, a8_addr, a8_data, a8_rw_n, cap_ready, ovf_clr,
    input  cap_valid, cap_addr, cap_data, cap_rw_n, ovf, clk_alive
  );

endinterface

// File: rtl/a8_cap_fifo.sv
// Capture FIFO with extra-bit pointers and a combinational head view.
// A8_CAPTURE_READS_EN adds storage for the rw_n bit; otherwise rw_n reads back as 0.
module a8_cap_fifo
  import a8_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  a8_cycle_t push_data_i,
  input  logic      pop_i,
  output a8_cycle_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW-1:0] waddr, raddr;
  logic            push_ok, pop_ok;

  logic [15:0] addr_mem_q [DEPTH];
  logic [15:0] addr_mem_d [DEPTH];
  logic [7:0]  data_mem_q [DEPTH];
  logic [7:0]  data_mem_d [DEPTH];
`ifdef A8_CAPTURE_READS_EN
  logic        rw_mem_q [DEPTH];
  logic        rw_mem_d [DEPTH];
`else
  logic        unused_rw_n;
  assign unused_rw_n = push_data_i.rw_n;
`endif

  assign waddr   = wptr_q[PtrW-1:0];
  assign raddr   = rptr_q[PtrW-1:0];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) && (waddr == raddr);

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
`ifdef A8_CAPTURE_READS_EN
    rw_mem_d   = rw_mem_q;
`endif
    if (push_ok) begin
      wptr_d            = wptr_q + 1'b1;
      addr_mem_d[waddr] = push_data_i.addr;
      data_mem_d[waddr] = push_data_i.data;
`ifdef A8_CAPTURE_READS_EN
      rw_mem_d[waddr]   = push_data_i.rw_n;
`endif
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_comb begin
    head_o.addr = addr_mem_q[raddr];
    head_o.data = data_mem_q[raddr];
`ifdef A8_CAPTURE_READS_EN
    head_o.rw_n = rw_mem_q[raddr];
`else
    head_o.rw_n = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: contents are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
`ifdef A8_CAPTURE_READS_EN
    rw_mem_q   <= rw_mem_d;
`endif
  end

endmodule

// File: rtl/a8_bus_capture.sv
// Samples the Atari bus once per phi2 cycle and queues writes in a window.
// A8_CAPTURE_READS_EN also captures reads in the window.
module a8_bus_capture
  import a8_bus_pkg::*;
#(
  parameter logic [TICK_W-1:0] SAMPLE_TICK = 7'd60,
  parameter logic [15:0]       ADDR_LO     = 16'hD500,
  parameter logic [15:0]       ADDR_HI     = 16'hD5FF,
  parameter int unsigned       FIFO_DEPTH  = 8
) (
  input logic              clk200,
  input logic              a8_rst_n,
  a8_bus_capture_if.slave  bus
);

  logic [2:0]        sync_q, sync_d;
  a8_cycle_t         stage_q, stage_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              sample_done_q, sample_done_d;
  logic              ovf_q, ovf_d;
  logic              clk_alive_q, clk_alive_d;

  logic      phi2_rise, sample, in_window, dir_ok, push, pop;
  logic      fifo_full, fifo_empty;
  a8_cycle_t head;

  assign phi2_rise = sync_q[1] & ~sync_q[2];
  assign sample    = (tick_q == SAMPLE_TICK) & ~sample_done_q;
  assign in_window = (stage_q.addr >= ADDR_LO) && (stage_q.addr <= ADDR_HI);
`ifdef A8_CAPTURE_READS_EN
  assign dir_ok    = 1'b1;
`else
  assign dir_ok    = ~stage_q.rw_n;
`endif
  assign push      = sample & in_window & dir_ok;
  assign pop       = ~fifo_empty & bus.cap_ready;

  always_comb begin
    sync_d       = {sync_q[1:0], bus.a8_clk};
    stage_d.addr = bus.a8_addr;
    stage_d.data = bus.a8_data;
    stage_d.rw_n = bus.a8_rw_n;

    if (phi2_rise) begin
      tick_d = '0;
    end else if (tick_q == TICK_MAX) begin
      tick_d = tick_q;
    end else begin
      tick_d = tick_q + 1'b1;
    end

    sample_done_d = sample_done_q;
    if (phi2_rise) begin
      sample_done_d = 1'b0;
    end else if (sample) begin
      sample_done_d = 1'b1;
    end

    // Set wins over clear when a drop coincides with ovf_clr.
    ovf_d = bus.ovf_clr ? 1'b0 : ovf_q;
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end

    // Tracks tick != TICK_MAX, so phi2 is declared dead once the counter saturates.
    clk_alive_d = (tick_d != TICK_MAX);
  end

  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      sync_q        <= '0;
      stage_q       <= '0;
      tick_q        <= TICK_MAX;
      sample_done_q <= 1'b1;
      ovf_q         <= 1'b0;
      clk_alive_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      stage_q       <= stage_d;
      tick_q        <= tick_d;
      sample_done_q <= sample_done_d;
      ovf_q         <= ovf_d;
      clk_alive_q   <= clk_alive_d;
    end
  end

  a8_cap_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk200),
    .rst_ni      (a8_rst_n),
    .push_i      (push),
    .push_data_i (stage_q),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.cap_valid = ~fifo_empty;
  assign bus.cap_addr  = head.addr;
  assign bus.cap_data  = head.data;
  assign bus.cap_rw_n  = head.rw_n;
  assign bus.ovf       = ovf_q;
  assign bus.clk_alive = clk_alive_q;

endmodule

// File: tb/tb_a8_bus_capture.sv
// Directed bench for a8_bus_capture: phi2 cycles are generated cycle-accurately
// from the clk200 falling edge so sample and flag timing can be checked exactly.
module tb_a8_bus_capture;
  import a8_bus_pkg::*;

  logic clk200   = 1'b0;
  logic a8_rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk200 = ~clk200;

  a8_bus_capture_if bus_if ();

  a8_bus_capture dut (
    .clk200   (clk200),
    .a8_rst_n (a8_rst_n),
    .bus      (bus_if.slave)
  );

  logic [15:0] wr_addr [9];
  logic [15:0] exp_addr [8];
  logic [7:0]  exp_data [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk200);
  endtask

  task automatic pop_one();
    bus_if.cap_ready = 1'b1;
    @(negedge clk200);
    bus_if.cap_ready = 1'b0;
  endtask

  task automatic set_bus(input logic [15:0] a, input logic [7:0] d, input logic rw);
    bus_if.a8_addr = a;
    bus_if.a8_data = d;
    bus_if.a8_rw_n = rw;
  endtask

  // One ~1.79 MHz phi2 cycle (112 clk200 periods); optional consumer pop in the sample cycle.
  task automatic phi2(input logic [15:0] a, input logic [7:0] d, input logic rw,
                      input bit pop_at_sample);
    set_bus(a, d, rw);
    bus_if.a8_clk = 1'b1;
    for (int i = 1; i <= 112; i++) begin
      @(negedge clk200);
      if (i == 56) bus_if.a8_clk = 1'b0;
      if (pop_at_sample) bus_if.cap_ready = (i == 63);
    end
  endtask

  initial begin
    bus_if.a8_clk    = 1'b0;
    bus_if.cap_ready = 1'b0;
    bus_if.ovf_clr   = 1'b0;
    set_bus(16'h0000, 8'h00, 1'b1);
    wr_addr = '{16'hD500, 16'hD5FF, 16'hD510, 16'hD520, 16'hD530,
                16'hD540, 16'hD550, 16'hD560, 16'hD570};

    // Reset state
    step(3);
    check("rst_cap_valid", bus_if.cap_valid, 0);
    check("rst_ovf", bus_if.ovf, 0);
    check("rst_clk_alive", bus_if.clk_alive, 0);
    a8_rst_n = 1'b1;
    step(2);
    check("post_rst_clk_alive", bus_if.clk_alive, 0);

    // Single in-window write: clk_alive three cycles after the edge, cap_valid after tick 60
    set_bus(16'hD501, 8'h5A, 1'b0);
    bus_if.a8_clk = 1'b1;
    step(2);
    check("alive_before_3", bus_if.clk_alive, 0);
    step(1);
    check("alive_at_3", bus_if.clk_alive, 1);
    step(60);
    check("valid_before_push", bus_if.cap_valid, 0);
    step(1);
    check("valid_after_push", bus_if.cap_valid, 1);
    check("first_addr", bus_if.cap_addr, 16'hD501);
    check("first_data", bus_if.cap_data, 8'h5A);
    check("first_rw_n", bus_if.cap_rw_n, 0);
    bus_if.a8_clk = 1'b0;
    step(48);
    check("one_entry_valid", bus_if.cap_valid, 1);
    pop_one();
    check("one_entry_only", bus_if.cap_valid, 0);

    // Out-of-window writes and an in-window read
    phi2(16'hD600, 8'h11, 1'b0, 1'b0);
    phi2(16'hD4FF, 8'h12, 1'b0, 1'b0);
    check("miss_window", bus_if.cap_valid, 0);
    phi2(16'hD510, 8'h22, 1'b1, 1'b0);
`ifdef A8_CAPTURE_READS_EN
    check("read_valid", bus_if.cap_valid, 1);
    check("read_addr", bus_if.cap_addr, 16'hD510);
    check("read_rw_n", bus_if.cap_rw_n, 1);
    pop_one();
`else
    check("read_ignored", bus_if.cap_valid, 0);
`endif

    // Short phi2 cycle: the edge arrives before tick 60, so only the following cycle samples
    set_bus(16'hD5C0, 8'h31, 1'b0);
    bus_if.a8_clk = 1'b1;
    step(20);
    bus_if.a8_clk = 1'b0;
    step(10);
    set_bus(16'hD5C4, 8'h32, 1'b0);
    bus_if.a8_clk = 1'b1;
    step(56);
    bus_if.a8_clk = 1'b0;
    step(56);
    check("short_valid", bus_if.cap_valid, 1);
    check("short_addr", bus_if.cap_addr, 16'hD5C4);
    check("short_data", bus_if.cap_data, 8'h32);
    pop_one();
    check("short_single", bus_if.cap_valid, 0);

    // Nine writes without consumer: eight kept, ninth dropped, ovf set
    for (int i = 0; i < 9; i++) begin
      phi2(wr_addr[i], 8'hA0 + 8'(i), 1'b0, 1'b0);
      if (i == 7) check("ovf_before_drop", bus_if.ovf, 0);
    end
    check("ovf_after_drop", bus_if.ovf, 1);
    check("full_head_addr", bus_if.cap_addr, 16'hD500);
    check("full_head_data", bus_if.cap_data, 8'hA0);
    bus_if.ovf_clr = 1'b1;
    step(1);
    bus_if.ovf_clr = 1'b0;
    check("ovf_cleared", bus_if.ovf, 0);

    // Full FIFO with a pop in the sample cycle: push accepted, order kept across wrap
    phi2(16'hD5AA, 8'h77, 1'b0, 1'b1);
    check("no_ovf_push_pop", bus_if.ovf, 0);
    for (int i = 0; i < 7; i++) begin
      exp_addr[i] = wr_addr[i + 1];
      exp_data[i] = 8'hA1 + 8'(i);
    end
    exp_addr[7] = 16'hD5AA;
    exp_data[7] = 8'h77;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid_%0d", i), bus_if.cap_valid, 1);
      check($sformatf("drain_addr_%0d", i), bus_if.cap_addr, exp_addr[i]);
      check($sformatf("drain_data_%0d", i), bus_if.cap_data, exp_data[i]);
      pop_one();
    end
    check("drained_empty", bus_if.cap_valid, 0);

    // Stopped phi2: clk_alive drops 127 ticks after the edge, no extra samples
    set_bus(16'hD5E0, 8'h44, 1'b0);
    bus_if.a8_clk = 1'b1;
    step(56);
    bus_if.a8_clk = 1'b0;
    step(73);
    check("alive_tick_126", bus_if.clk_alive, 1);
    step(1);
    check("dead_tick_127", bus_if.clk_alive, 0);
    step(200);
    check("stopped_valid", bus_if.cap_valid, 1);
    check("stopped_addr", bus_if.cap_addr, 16'hD5E0);
    pop_one();
    check("stopped_single", bus_if.cap_valid, 0);

    // Reset with three entries queued
    phi2(16'hD501, 8'h01, 1'b0, 1'b0);
    phi2(16'hD502, 8'h02, 1'b0, 1'b0);
    phi2(16'hD503, 8'h03, 1'b0, 1'b0);
    check("queued_valid", bus_if.cap_valid, 1);
    #2;
    a8_rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus_if.cap_valid, 0);
    @(negedge clk200);
    a8_rst_n = 1'b1;
    step(2);
    check("post_rst2_valid", bus_if.cap_valid, 0);
    check("post_rst2_alive", bus_if.clk_alive, 0);
    phi2(16'hD5FE, 8'h99, 1'b0, 1'b0);
    check("post_rst2_addr", bus_if.cap_addr, 16'hD5FE);
    check("post_rst2_data", bus_if.cap_data, 8'h99);
    pop_one();
    check("post_rst2_empty", bus_if.cap_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/a8_bus_capture.md
A8_BUS_CAPTURE -- requirements
Module: a8_bus_capture

Interface
REQ-001 Parameter SAMPLE_TICK, default 7'd60: clk200 ticks after the detected a8_clk rising edge at which the bus is sampled; legal range 1..126.
REQ-002 Parameter ADDR_LO, default 16'hD500: lowest captured address, inclusive.
REQ-003 Parameter ADDR_HI, default 16'hD5FF: highest captured address, inclusive.
REQ-004 Parameter FIFO_DEPTH, default 8: capture FIFO entries; power of two, 2..64.
REQ-005 clk200  input  1: the single clock, 200 MHz; all logic is on its rising edge.
REQ-006 a8_rst_n  input  1: reset, asynchronous and active-low.
REQ-007 a8_clk  input  1: Atari phi2, asynchronous to clk200.
REQ-008 a8_addr  input  16: Atari address bus.
REQ-009 a8_data  input  8: Atari data bus.
REQ-010 a8_rw_n  input  1: Atari read/write; 0 means write.
REQ-011 cap_valid  output  1: head FIFO entry is available.
REQ-012 cap_ready  input  1: consumer accepts the head entry.
REQ-013 cap_addr, cap_data, cap_rw_n  output  16/8/1: head entry fields.
REQ-014 ovf  output  1: sticky flag; a matching cycle was dropped because the FIFO was full.
REQ-015 ovf_clr  input  1: clears ovf.
REQ-016 clk_alive  output  1: phi2 edges are being seen.

Function
REQ-017 a8_clk SHALL pass through a 3-flop synchroniser s[0..2]; a rising edge is detected when s[1] & ~s[2].
REQ-018 a8_addr, a8_data and a8_rw_n SHALL be registered once per clk200 into a bus stage; all samples are taken from this stage.
REQ-019 A 7-bit tick counter SHALL load 0 on the detected edge, otherwise increment, and saturate at 127.
REQ-020 Sampling SHALL occur exactly once per phi2 cycle, in the cycle where tick == SAMPLE_TICK and the sample_done flag is clear; sample_done is set on sampling and cleared on edge.
REQ-021 A sample SHALL match when ADDR_LO <= addr <= ADDR_HI (unsigned 16-bit) and rw_n == 0; the read case is governed by REQ-031.
REQ-022 A matching sample SHALL be pushed into the FIFO in the same cycle; cap_valid rises the next cycle if the FIFO was empty.
REQ-023 Pop SHALL occur on cap_valid & cap_ready; the cap_* outputs show the head entry combinationally from FIFO storage.
REQ-024 Full FIFO with a matching sample and no pop: the sample is dropped and ovf is set next cycle; FIFO contents are unchanged.
REQ-025 Full FIFO with a matching sample and a pop in the same cycle: the push is accepted and the count is unchanged.
REQ-026 Empty FIFO with a push: no pop is possible that cycle.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full and empty are derived from an extra pointer bit.
REQ-028 ovf_clr and an overflow in the same cycle: ovf remains set (set wins).
REQ-029 clk_alive SHALL be 1 after a detected edge and 0 while tick == 127.
REQ-030 With an edge arriving before SAMPLE_TICK is reached, no sample is taken for the short cycle and the counter restarts.

Configuration
REQ-031 Macro A8_CAPTURE_READS_EN: when defined, matching reads (rw_n == 1) are captured as well as writes, with cap_rw_n = 1; when undefined, only writes are captured and cap_rw_n is constant 0 with no storage bit.

Reset
REQ-032 On a8_rst_n low, and until the first clock after release: s[0..2] = 0, tick = 127, sample_done = 1, pointers = 0, cap_valid = 0, ovf = 0, clk_alive = 0, and the bus stage = 0.
REQ-033 Reset asserted mid-operation SHALL discard FIFO contents; no partial entry is visible after release.

Structure
REQ-034 Package a8_bus_pkg SHALL hold the a8_cycle_t struct (addr, data, rw_n), the TICK_W = 7 constant and the TICK_MAX = 127 constant.
REQ-035 The FIFO SHALL be a sub-module a8_cap_fifo (parameter DEPTH, payload a8_cycle_t, push/pop/full/empty); the synchroniser, counter and decode stay in a8_bus_capture.

Verification
REQ-036 Phi2 at 1.79 MHz with a write of 8'h5A to 16'hD501 held across the sample point -> exactly one entry {D501, 5A, 0}, with cap_valid high 1 cycle after the tick-60 sample.
REQ-037 Write to 16'hD600, and (without the macro) a read from 16'hD510 -> no entry; with A8_CAPTURE_READS_EN, the read yields {D510, xx, 1}.
REQ-038 Nine matching writes with cap_ready = 0 -> eight entries in order, ninth dropped, ovf = 1; a pulse on ovf_clr -> ovf = 0.
REQ-039 FIFO full, cap_ready = 1 held through the next matching sample -> the push is accepted, count stays 8, and data order is preserved across pointer wrap.
REQ-040 Stop a8_clk -> clk_alive = 0 at 127 ticks after the last edge, and no samples are taken; restart -> clk_alive = 1 three cycles after the input edge.
REQ-041 Assert a8_rst_n with 3 entries queued -> cap_valid = 0 immediately (asynchronous); after release, the FIFO is empty.
